// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, in-order imem request/response tracking and redirect drain.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.

module fetch_stage_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic          clear,
    input logic [CW-1:0] cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !clear && (cnt == CW'(DEPTH))));
endmodule

module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
    parameter int               MAX_OUTST = 2,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic             FetchEmpty
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cyc,
    output logic [31:0]      perf_redirects
`endif
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW:0]     MAX_SUM = (CW + 1)'(MAX_OUTST);
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(32'd4);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [XLEN-1:0]   pcf_r;
    logic [CW-1:0]     outst_r;
    logic [CW-1:0]     drop_r;
    logic [CW-1:0]     drop_nxt_s;

    logic [XLEN-1:0]   pcq_r [MAX_OUTST];
    logic [PW-1:0]     pcq_wr_r;
    logic [PW-1:0]     pcq_rd_r;

    logic [XLEN-1:0]   fifo_pc_r    [MAX_OUTST];
    logic [31:0]       fifo_instr_r [MAX_OUTST];
    logic [PW-1:0]     fifo_wr_r;
    logic [PW-1:0]     fifo_rd_r;
    logic [CW-1:0]     fifo_cnt_r;

    logic              accept_s;
    logic              rsp_any_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_nonempty_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // Handshake and queue movement qualifiers
    assign fifo_nonempty_s = (fifo_cnt_r != {CW{1'b0}});
    assign imem_req_valid  = !rst && (state_r == ST_RUN) && !StallF && !PCSrcE &&
                             (({1'b0, outst_r} + {1'b0, fifo_cnt_r}) < MAX_SUM);
    assign imem_req_addr   = pcf_r;
    assign accept_s        = imem_req_valid && imem_req_ready;
    assign rsp_any_s       = imem_rsp_valid && (outst_r != {CW{1'b0}});
    assign push_s          = rsp_any_s && (state_r == ST_RUN) && !PCSrcE;
    assign pop_s           = !FlushD && !StallD && fifo_nonempty_s;
    assign FetchEmpty      = !fifo_nonempty_s;

    // Next-state and drop-count logic; a redirect re-arms drop from every request still in flight
    always_comb begin
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        if (PCSrcE) begin
            drop_nxt_s = outst_r - CW'(rsp_any_s);
            if (drop_nxt_s != {CW{1'b0}}) begin
                state_nxt_s = ST_DRAIN;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    state_nxt_s = ST_RUN;
                end
                ST_DRAIN: begin
                    if (rsp_any_s && (drop_r != {CW{1'b0}})) begin
                        drop_nxt_s = drop_r - CW'(1'b1);
                    end else begin
                        drop_nxt_s = drop_r;
                    end
                    if (drop_nxt_s == {CW{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    drop_nxt_s  = {CW{1'b0}};
                end
            endcase
        end
    end

    // FSM, PC, outstanding counter and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            drop_r     <= {CW{1'b0}};
            outst_r    <= {CW{1'b0}};
            pcf_r      <= RESET_PC;
            pcq_wr_r   <= {PW{1'b0}};
            pcq_rd_r   <= {PW{1'b0}};
            fifo_wr_r  <= {PW{1'b0}};
            fifo_rd_r  <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            drop_r  <= drop_nxt_s;
            outst_r <= outst_r + CW'(accept_s) - CW'(rsp_any_s);
            if (PCSrcE) begin
                pcf_r      <= PCTargetE;
                pcq_wr_r   <= {PW{1'b0}};
                pcq_rd_r   <= {PW{1'b0}};
                fifo_wr_r  <= {PW{1'b0}};
                fifo_rd_r  <= {PW{1'b0}};
                fifo_cnt_r <= {CW{1'b0}};
            end else begin
                if (accept_s) begin
                    pcf_r    <= pcf_r + PC_INC;
                    pcq_wr_r <= ptr_inc(pcq_wr_r);
                end
                if (push_s) begin
                    pcq_rd_r  <= ptr_inc(pcq_rd_r);
                    fifo_wr_r <= ptr_inc(fifo_wr_r);
                end
                if (pop_s) begin
                    fifo_rd_r <= ptr_inc(fifo_rd_r);
                end
                fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    // Storage for the in-flight PC queue and the response FIFO
    always_ff @(posedge clk) begin
        if (accept_s && !PCSrcE) begin
            pcq_r[pcq_wr_r] <= pcf_r;
        end
        if (push_s) begin
            fifo_pc_r[fifo_wr_r]    <= pcq_r[pcq_rd_r];
            fifo_instr_r[fifo_wr_r] <= imem_rsp_data;
        end
    end

    // IF/ID register; bubbles keep the last PC so a stalled or flushed slot stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= {XLEN{1'b0}};
            PCPlus4D <= {XLEN{1'b0}};
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (fifo_nonempty_s) begin
            InstrD   <= fifo_instr_r[fifo_rd_r];
            PCD      <= fifo_pc_r[fifo_rd_r];
            PCPlus4D <= fifo_pc_r[fifo_rd_r] + PC_INC;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Stall-cycle and redirect event counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= 32'd0;
            perf_redirects <= 32'd0;
        end else begin
            if (StallF) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (PCSrcE) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

    fetch_stage_chk #(
        .DEPTH (MAX_OUTST),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .clear (PCSrcE),
        .cnt   (fifo_cnt_r)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable memory model feeds expected PCs
// to a queue that an independent ID-stage monitor drains and compares.

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchEmpty;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_redirects;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD),
        .FetchEmpty     (FetchEmpty)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_redirects (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_instr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    // expected PCs, in the order the ID stage must present them
    logic [31:0] sb_q[$];

    // memory model state
    logic [31:0] pend_addr[$];
    int          pend_wait[$];
    bit          pend_stale[$];
    int          lat = 1;
    logic [31:0] model_addr = 32'h0;
    logic        mem_acc, mem_rv, mem_red, mem_rst;
    logic [31:0] mem_addr, mem_tgt;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    end

    // memory: in-order responses `lat` cycles after accept; redirect marks in-flight entries stale
    always @(posedge clk) begin
        mem_acc  = imem_req_valid && imem_req_ready;
        mem_addr = imem_req_addr;
        mem_rv   = imem_rsp_valid;
        mem_red  = PCSrcE;
        mem_tgt  = PCTargetE;
        mem_rst  = rst;
        #1;
        if (mem_rst) begin
            pend_addr.delete();
            pend_wait.delete();
            pend_stale.delete();
            model_addr = 32'h0;
        end else begin
            if (mem_rv && pend_addr.size() > 0) begin
                if (!pend_stale[0] && !mem_red) sb_q.push_back(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_wait.pop_front());
                void'(pend_stale.pop_front());
            end
            foreach (pend_wait[i]) if (pend_wait[i] > 0) pend_wait[i] = pend_wait[i] - 1;
            if (mem_red) begin
                foreach (pend_stale[i]) pend_stale[i] = 1'b1;
                model_addr = mem_tgt;
            end
            if (mem_acc) begin
                chk("req_addr", mem_addr, model_addr);
                pend_addr.push_back(model_addr);
                pend_wait.push_back(lat - 1);
                pend_stale.push_back(1'b0);
                model_addr = model_addr + 32'd4;
            end
        end
        if (pend_addr.size() > 0 && pend_wait[0] == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // ID monitor
    logic        mon_sd, mon_fd, mon_rst;
    logic        last_valid = 1'b0;
    logic [31:0] last_pc    = 32'h0;
    logic [31:0] last_instr = NOP;
    logic [31:0] exp_pc;

    always @(posedge clk) begin
        mon_sd  = StallD;
        mon_fd  = FlushD;
        mon_rst = rst;
        #2;
        if (!mon_rst) begin
            if (mon_fd) begin
                chk("flush_valid", 32'(ValidD), 32'd0);
                chk("flush_instr", InstrD, NOP);
                last_valid = 1'b0;
                last_instr = NOP;
            end else if (mon_sd) begin
                chk("hold_valid", 32'(ValidD), 32'(last_valid));
                chk("hold_pc", PCD, last_pc);
                chk("hold_instr", InstrD, last_instr);
            end else if (ValidD) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL id_unexpected: got PCD %h while no instruction expected", PCD);
                end else begin
                    exp_pc = sb_q.pop_front();
                    chk("id_pc", PCD, exp_pc);
                    chk("id_instr", InstrD, instr_of(exp_pc));
                    chk("id_pc4", PCPlus4D, exp_pc + 32'd4);
                    n_instr++;
                    last_valid = 1'b1;
                    last_pc    = exp_pc;
                    last_instr = instr_of(exp_pc);
                end
            end else begin
                chk("bubble_instr", InstrD, NOP);
                last_valid = 1'b0;
                last_instr = NOP;
            end
        end
    end

    // expected performance counts
    int exp_stall = 0;
    int exp_redir = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (StallF) exp_stall++;
            if (PCSrcE) exp_redir++;
        end
    end

    logic got;

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; imem_req_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_empty", 32'(FetchEmpty), 32'd1);
        chk("rst_reqv", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;

        // first valid instruction on the third rising edge after reset release
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #2;
            chk("lat_valid", 32'(ValidD), 32'(i == 3));
        end
        chk("first_pcd", PCD, 32'h0);
        chk("first_instr", InstrD, instr_of(32'h0));
        @(negedge clk);
        repeat (4) @(negedge clk);

        // front end and decode both stalled
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_noreq", 32'(imem_req_valid), 32'd0);
            @(negedge clk);
        end
        StallF = 1'b0; StallD = 1'b0;
        repeat (6) @(negedge clk);

        // redirect with two requests in flight at latency 3
        StallF = 1'b1;
        repeat (6) @(negedge clk);
        lat = 3; StallF = 1'b0;
        repeat (2) @(negedge clk);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
        #1 chk("redir_noreq", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        PCSrcE = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ValidD) got = 1'b1;
        end
        chk("redir_seen", 32'(got), 32'd1);
        chk("redir_pcd", PCD, 32'h0000_0100);
        repeat (6) @(negedge clk);

        // flush while the response FIFO holds work
        lat = 1; StallD = 1'b1;
        repeat (5) @(negedge clk);
        #1 chk("flush_fifo_busy", 32'(FetchEmpty), 32'd0);
        StallD = 1'b0; FlushD = 1'b1;
        @(negedge clk);
        FlushD = 1'b0;
        chk("flush_bubble", 32'(ValidD), 32'd0);
        @(negedge clk);
        chk("post_flush_valid", 32'(ValidD), 32'd1);
        repeat (4) @(negedge clk);

        // memory back-pressure
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rdy_pcf_hold", imem_req_addr, model_addr);
            @(negedge clk);
        end
        chk("rdy_bubble", 32'(ValidD), 32'd0);
        chk("rdy_empty", 32'(FetchEmpty), 32'd1);
        imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);

        // address wrap; redirect overrides StallF
        StallF = 1'b1;
        repeat (6) @(negedge clk);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        @(negedge clk);
        PCSrcE = 1'b0; StallF = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h0) got = 1'b1;
        end
        chk("wrap_addr_zero", 32'(got), 32'd1);
        repeat (8) @(negedge clk);

        StallF = 1'b1;
        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("instr_count", 32'(n_instr >= 10), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cyc, 32'(exp_stall));
        chk("perf_redir", perf_redirects, 32'(exp_redir));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
